// File: rtl/nco_pkg.sv
// Shared constants and FSM encoding for the NCO tuning/sweep controllers.
package nco_pkg;

    localparam int NCO_WIDTH = 64;

    localparam logic MODE_SET   = 1'b0;
    localparam logic MODE_SWEEP = 1'b1;

    // DWELL: holding a value with more cycles to go.
    // STEP:  last cycle of a non-final value; the next value is loaded on exit.
    // DONE:  last cycle of the final value; the sweep completes on exit.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_STEP  = 2'd2,
        ST_DONE  = 2'd3
    } nco_state_e;

endpackage

// File: rtl/nco_dwell_timer.sv
// Loadable down-counter tracking the remaining cycles of a hold interval.
// expire flags the last cycle of the interval, near_expire the one before it,
// so a controller can register its "last cycle" state one cycle ahead.
module nco_dwell_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expire,
    output logic         near_expire
);

    logic [W-1:0] cnt_q, cnt_d;

    // Reload has priority over counting; the counter parks at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (en && cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expire      = (cnt_q == W'(1));
    assign near_expire = (cnt_q == W'(2));

endmodule

// File: rtl/nco_tune_ctrl.sv
// Carrier NCO frequency-word sequencer: one-shot SET retunes and linear
// SWEEPs with signed step, step count and per-step dwell.
module nco_tune_ctrl
    import nco_pkg::*;
#(
    parameter int WIDTH   = NCO_WIDTH,
    parameter int CNT_W   = 16,
    parameter int DWELL_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_mode,
    input  logic [WIDTH-1:0]   cmd_freq,
    input  logic [WIDTH-1:0]   cmd_step,
    input  logic [CNT_W-1:0]   cmd_count,
    input  logic [DWELL_W-1:0] cmd_dwell,
    input  logic               abort,
    output logic [WIDTH-1:0]   phase_inc_carr,
    output logic               inc_update,
    output logic [CNT_W-1:0]   step_idx,
    output logic               busy,
    output logic               sweep_done
);

    nco_state_e         state_q, state_d;
    logic [WIDTH-1:0]   inc_q, inc_d;
    logic [WIDTH-1:0]   step_q, step_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               upd_q, upd_d;
    logic               done_q, done_d;

    logic               accept;
    logic [DWELL_W-1:0] dwell_eff;
    logic [CNT_W-1:0]   idx_nxt;
    logic               tmr_load, tmr_en, tmr_expire, tmr_near;
    logic [DWELL_W-1:0] tmr_val;

    // abort blocks acceptance even in IDLE.
    assign cmd_ready = (state_q == ST_IDLE) && !abort;
    assign accept    = cmd_valid && cmd_ready;
    assign dwell_eff = (cmd_dwell == '0) ? DWELL_W'(1) : cmd_dwell;
    assign idx_nxt   = idx_q + CNT_W'(1);

    nco_dwell_timer #(.W(DWELL_W)) u_dwell (
        .clk         (clk),
        .rst         (rst),
        .load        (tmr_load),
        .load_val    (tmr_val),
        .en          (tmr_en),
        .expire      (tmr_expire),
        .near_expire (tmr_near)
    );

    // Next-state, output word and timer control.
    always_comb begin
        state_d  = state_q;
        inc_d    = inc_q;
        step_d   = step_q;
        idx_d    = idx_q;
        count_d  = count_q;
        dwell_d  = dwell_q;
        upd_d    = 1'b0;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = dwell_q;
        tmr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    inc_d = cmd_freq;
                    idx_d = '0;
                    upd_d = 1'b1;
                    if (cmd_mode == MODE_SWEEP) begin
                        step_d   = cmd_step;
                        count_d  = cmd_count;
                        dwell_d  = dwell_eff;
                        tmr_load = 1'b1;
                        tmr_val  = dwell_eff;
                        if (dwell_eff != DWELL_W'(1))
                            state_d = ST_DWELL;
                        else
                            state_d = (cmd_count == '0) ? ST_DONE : ST_STEP;
                    end
                end
            end
            ST_DWELL: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_near)
                        state_d = (idx_q < count_q) ? ST_STEP : ST_DONE;
                end
            end
            ST_STEP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tmr_expire) begin
                    // Wraps silently modulo 2^WIDTH.
                    inc_d    = inc_q + step_q;
                    idx_d    = idx_nxt;
                    upd_d    = 1'b1;
                    tmr_load = 1'b1;
                    if (dwell_q != DWELL_W'(1))
                        state_d = ST_DWELL;
                    else
                        state_d = (idx_nxt == count_q) ? ST_DONE : ST_STEP;
                end else begin
                    state_d = ST_DWELL;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = !abort;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            inc_q   <= '0;
            step_q  <= '0;
            idx_q   <= '0;
            count_q <= '0;
            dwell_q <= DWELL_W'(1);
            upd_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inc_q   <= inc_d;
            step_q  <= step_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            dwell_q <= dwell_d;
            upd_q   <= upd_d;
            done_q  <= done_d;
        end
    end

    assign phase_inc_carr = inc_q;
    assign inc_update     = upd_q;
    assign step_idx       = idx_q;
    assign busy           = (state_q != ST_IDLE);
    assign sweep_done     = done_q;

endmodule

// File: tb/tb_nco_tune_ctrl.sv
// Bench for nco_tune_ctrl: directed scenarios plus random traffic, checked
// every cycle against a schedule-based model (value k of a sweep shows at
// accept+1+k*D, completion at accept+1+(count+1)*D).
module tb_nco_tune_ctrl;

    localparam int WIDTH   = 64;
    localparam int CNT_W   = 16;
    localparam int DWELL_W = 24;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_mode;
    logic [WIDTH-1:0]   cmd_freq;
    logic [WIDTH-1:0]   cmd_step;
    logic [CNT_W-1:0]   cmd_count;
    logic [DWELL_W-1:0] cmd_dwell;
    logic               abort;
    logic [WIDTH-1:0]   phase_inc_carr;
    logic               inc_update;
    logic [CNT_W-1:0]   step_idx;
    logic               busy;
    logic               sweep_done;

    always #5 clk = ~clk;

    nco_tune_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DWELL_W(DWELL_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_mode       (cmd_mode),
        .cmd_freq       (cmd_freq),
        .cmd_step       (cmd_step),
        .cmd_count      (cmd_count),
        .cmd_dwell      (cmd_dwell),
        .abort          (abort),
        .phase_inc_carr (phase_inc_carr),
        .inc_update     (inc_update),
        .step_idx       (step_idx),
        .busy           (busy),
        .sweep_done     (sweep_done)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    longint     n = 0;
    longint     m_t0, m_cnt, m_d;
    logic [63:0] m_freq, m_step, m_val;
    logic [15:0] m_idx;
    logic        m_busy, m_upd, m_done;

    task automatic model_reset();
        m_busy = 0; m_upd = 0; m_done = 0; m_val = '0; m_idx = '0;
    endtask

    task automatic model_edge();
        longint j;
        if (rst) begin
            model_reset();
        end else begin
            m_upd  = 0;
            m_done = 0;
            if (m_busy && abort) begin
                m_busy = 0;
            end else if (m_busy) begin
                j = n - m_t0;
                if (j == (m_cnt + 1) * m_d) begin
                    m_busy = 0;
                    m_done = 1;
                end else if (j % m_d == 0) begin
                    m_val = m_freq + 64'(j / m_d) * m_step;
                    m_idx = 16'(j / m_d);
                    m_upd = 1;
                end
            end else if (cmd_valid && !abort) begin
                m_val = cmd_freq;
                m_idx = '0;
                m_upd = 1;
                if (cmd_mode) begin
                    m_busy = 1;
                    m_t0   = n;
                    m_freq = cmd_freq;
                    m_step = cmd_step;
                    m_cnt  = longint'(cmd_count);
                    m_d    = (cmd_dwell == 0) ? 1 : longint'(cmd_dwell);
                end
            end
        end
    endtask

    // One clock with the currently driven inputs; checks ready mid-cycle
    // and all registered outputs just after the edge.
    task automatic tick();
        @(negedge clk);
        chk("cmd_ready", 64'(cmd_ready), 64'(!m_busy && !abort));
        @(posedge clk);
        n++;
        model_edge();
        #1;
        chk("phase_inc", phase_inc_carr, m_val);
        chk("inc_update", 64'(inc_update), 64'(m_upd));
        chk("step_idx", 64'(step_idx), 64'(m_idx));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("sweep_done", 64'(sweep_done), 64'(m_done));
    endtask

    task automatic idle(input int cycles);
        cmd_valid = 0; abort = 0; rst = 0;
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic issue(input logic mode, input logic [63:0] f, input logic [63:0] s,
                         input logic [15:0] c, input logic [23:0] d);
        cmd_valid = 1; cmd_mode = mode; cmd_freq = f; cmd_step = s;
        cmd_count = c; cmd_dwell = d;
        tick();
        cmd_valid = 0;
    endtask

    initial begin
        int guard;
        model_reset();
        rst = 1; cmd_valid = 0; abort = 0; cmd_mode = 0;
        cmd_freq = '0; cmd_step = '0; cmd_count = '0; cmd_dwell = '0;
        tick(); tick();
        chk("reset_phase", phase_inc_carr, 64'h0);
        chk("reset_ready", 64'(cmd_ready), 64'h1);
        idle(1);

        // Single retune, then back-to-back SETs
        issue(1'b0, 64'h0000_0400_0000_0000, 0, 0, 0);
        chk("set_value", phase_inc_carr, 64'h0000_0400_0000_0000);
        issue(1'b0, 64'h1234, 0, 0, 0);
        issue(1'b0, 64'h5678, 0, 0, 0);
        idle(2);

        // Upward sweep 100/110/120/130, dwell 4
        issue(1'b1, 64'd100, 64'd10, 16'd3, 24'd4);
        idle(20);
        chk("sweep_final", phase_inc_carr, 64'd130);

        // Negative step with wrap, dwell 0 treated as 1
        issue(1'b1, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 16'd2, 24'd0);
        idle(6);
        chk("wrap_final", phase_inc_carr, 64'hFFFF_FFFF_FFFF_FFFF);

        // Abort at T+12 with a SET held pending through it
        issue(1'b1, 64'd0, 64'd1, 16'd10, 24'd8);
        cmd_valid = 1; cmd_mode = 0; cmd_freq = 64'd77;
        for (int i = 1; i <= 12; i++) begin
            abort = (i == 12);
            tick();
        end
        chk("abort_frozen", phase_inc_carr, 64'd1);
        chk("abort_busy", 64'(busy), 64'h0);
        abort = 0;
        tick();
        chk("pending_set", phase_inc_carr, 64'd77);
        idle(3);

        // count=0, dwell=1
        issue(1'b1, 64'd42, 64'd9, 16'd0, 24'd1);
        idle(3);

        // Reset mid-sweep
        issue(1'b1, 64'd1000, 64'd3, 16'd5, 24'd3);
        idle(4);
        rst = 1; tick(); rst = 0;
        chk("midrst_phase", phase_inc_carr, 64'h0);
        idle(2);

        // SET held while a sweep runs
        issue(1'b1, 64'd500, 64'd0, 16'd2, 24'd2);
        cmd_valid = 1; cmd_mode = 0; cmd_freq = 64'hABCD;
        guard = 0;
        while (!(cmd_ready && cmd_valid) && guard < 50) begin tick(); guard++; end
        chk("busy_set_timeout", 64'(guard < 50), 64'h1);
        tick();
        chk("busy_set_value", phase_inc_carr, 64'hABCD);
        idle(2);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            abort     = ($urandom_range(0, 29) == 0);
            cmd_valid = $urandom_range(0, 1);
            cmd_mode  = $urandom_range(0, 1);
            cmd_freq  = {$urandom, $urandom};
            cmd_step  = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
            cmd_count = 16'($urandom_range(0, 4));
            cmd_dwell = 24'($urandom_range(0, 3));
            tick();
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/nco_tune_ctrl.md
Name: nco_tune_ctrl

Overview:
- Sequences the frequency word (phase_inc_carr) driven into the nco_sig carrier NCO.
- Accepts tuning commands over a valid/ready handshake. Two command types:
  - SET: a one-shot retune.
  - SWEEP: a linear frequency sweep with programmable start, signed step, step count and per-step dwell.
- Sits between the host/command logic and the NCO. The NCO sees only a registered, glitch-free increment word.

Parameters:
- WIDTH, 64: phase increment width; must equal the NCO WIDTH.
- CNT_W, 16: step-count / step-index width.
- DWELL_W, 24: dwell counter width, in clk cycles.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- rst, input, 1: synchronous, active-high reset.
- cmd_valid, input, 1: command present.
- cmd_ready, output, 1: controller can accept a command.
- cmd_mode, input, 1: 0 = SET, 1 = SWEEP.
- cmd_freq, input, WIDTH: SET value / SWEEP start increment.
- cmd_step, input, WIDTH: signed two's-complement increment delta per step.
- cmd_count, input, CNT_W: number of steps after the start value.
- cmd_dwell, input, DWELL_W: cycles each value is held; 0 is treated as 1.
- abort, input, 1: terminate a sweep in progress.
- phase_inc_carr, output, WIDTH: registered increment to the NCO.
- inc_update, output, 1: 1-cycle pulse in the first cycle a new phase_inc_carr value is visible.
- step_idx, output, CNT_W: index of the value currently output (0 = start).
- busy, output, 1: sweep in progress.
- sweep_done, output, 1: 1-cycle pulse on normal sweep completion.

Behaviour:
- Reset values: phase_inc_carr=0, inc_update=0, step_idx=0, busy=0, sweep_done=0, cmd_ready=1, state=IDLE.
- Reset mid-sweep discards the sweep. The next cycle shows the reset values.
- cmd_ready = (state==IDLE) & ~abort. A command is accepted on cycle T when cmd_valid & cmd_ready. Command fields are captured at T only.
- States: IDLE, DWELL, STEP, DONE.
- SET accepted at T:
  - T+1: phase_inc_carr=cmd_freq, inc_update=1, step_idx=0.
  - State stays IDLE; cmd_ready stays 1, so back-to-back SETs are legal every cycle.
- SWEEP accepted at T:
  - T+1: phase_inc_carr=cmd_freq, inc_update=1, step_idx=0, busy=1, state=DWELL.
  - The dwell counter loads D = max(cmd_dwell,1).
- Hold time: each output value is held exactly D cycles. Value k first appears at T+1+k·D, for k = 0..cmd_count.
- Dwell expiry:
  - If step_idx < count: STEP adds step (modulo 2^WIDTH, wrap-around silent, no saturation) and increments step_idx. The STEP cycle is the last cycle of the current value, not an extra cycle.
  - If step_idx == count: go to DONE.
- DONE:
  - At T+1+(count+1)·D: sweep_done=1, busy=0, state=IDLE, cmd_ready=1.
  - phase_inc_carr keeps the final value.
- cmd_count=0: the start value is held D cycles, then sweep_done.
- abort during DWELL/STEP:
  - Next cycle: state=IDLE, busy=0.
  - phase_inc_carr holds its current value; no further inc_update; no sweep_done.
  - abort in IDLE has no effect, apart from blocking acceptance that cycle.
- abort has priority over cmd accept in the same cycle.
- cmd_valid while busy: not accepted, because cmd_ready=0. The command stays pending per the handshake.
- inc_update is never asserted when the value is unchanged by an abort. It is asserted on every STEP, even if step=0.

Decomposition:
- Shared package nco_pkg:
  - Constants NCO_WIDTH=64 and MODE_SET=0 / MODE_SWEEP=1.
  - State encoding constants for the FSM.
- One natural sub-module: nco_dwell_timer. It provides a load/decrement counter with an `expire` output and is reused by future hop/scan controllers.

Test Plan:
- Reset then SET: rst 2 cycles; SET freq=0x0000_0400_0000_0000 at T.
  - Required: phase_inc_carr=0 before T+1 and =0x0000_0400_0000_0000 at T+1, inc_update at T+1 only, cmd_ready always 1.
- SWEEP freq=100, step=10, count=3, dwell=4 at T.
  - Required: values 100/110/120/130 first visible at T+1/T+5/T+9/T+13, with inc_update each time and step_idx 0..3.
  - sweep_done at T+17; busy high T+1..T+16; final value 130 held.
- Negative step with wrap: freq=5, step=-3 (all-ones minus 2), count=2, dwell=0.
  - Required: values 5, 2, 2^64-1, each held 1 cycle; sweep_done at T+4.
- abort: SWEEP freq=0, step=1, count=10, dwell=8; abort at T+12.
  - Required: state IDLE and busy=0 at T+13; phase_inc_carr=1 frozen; no sweep_done.
  - A cmd_valid held high through T+12 is accepted at T+13, not T+12.
- Edge cases:
  - count=0, dwell=1: sweep_done at T+2.
  - Reset asserted mid-sweep: all outputs return to reset values on the next cycle.
  - SET issued while busy: not accepted until DONE.
